// File: rtl/fir_txn_driver_if.sv
// Stream, core-handshake and status bundle for fir_txn_driver.
// master = the driver itself, slave = its environment.
interface fir_txn_driver_if #(
   parameter int DW = 16,
   parameter int OW = 32,
   parameter int CW = 16
);
   logic [DW-1:0] s_data;
   logic          s_valid;
   logic          s_ready;
   logic          ap_start;
   logic [DW-1:0] ap_x;
   logic          ap_ready;
   logic          ap_done;
   logic [OW-1:0] ap_y;
   logic          ap_y_vld;
   logic [OW-1:0] m_data;
   logic          m_valid;
   logic          m_ready;
   logic [CW-1:0] txn_count;
   logic          finish;

   modport master (
      input  s_data, s_valid, ap_ready, ap_done,
      input  ap_y, ap_y_vld, m_ready,
      output s_ready, ap_start, ap_x, m_data,
      output m_valid, txn_count, finish
   );

   modport slave (
      output s_data, s_valid, ap_ready, ap_done,
      output ap_y, ap_y_vld, m_ready,
      input  s_ready, ap_start, ap_x, m_data,
      input  m_valid, txn_count, finish
   );
endinterface

// File: rtl/fir_txn_driver.sv
// Upstream transaction driver for fir_filter with result FIFO.
// Optional stall counter enabled by FIR_DRV_STALL_CNT_EN.
module fir_txn_driver #(
   parameter int DW          = 16,
   parameter int OW          = 32,
   parameter int OFIFO_DEPTH = 4,
   parameter int NUM_TXN     = 64,
   parameter int CW          = 16
) (
   input  logic              clock,
   input  logic              reset,
`ifdef FIR_DRV_STALL_CNT_EN
   output logic [31:0]       stall_cycles,
`endif
   fir_txn_driver_if.master  bus
);
   localparam int AW = $clog2(OFIFO_DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(OFIFO_DEPTH);
   localparam logic [CW-1:0] NUM_C = CW'(NUM_TXN);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] BUSY  = 2'd2;
   localparam logic [1:0] FIN   = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [DW-1:0] x_q, x_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   logic          fin_q;
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   occ_q;
   logic [OW-1:0] mem_q [OFIFO_DEPTH];

   logic accept, done_ev, push, pop;
   logic last, fin_now;

   assign cnt_inc = cnt_q + 1'b1;
   assign last    = (NUM_TXN != 0) && (cnt_inc == NUM_C);

   assign bus.s_ready = !reset && (state_q == IDLE)
                        && (occ_q != FULL) && !fin_q;
   assign bus.ap_start  = (state_q == START);
   assign bus.ap_x      = x_q;
   assign bus.m_valid   = (occ_q != '0);
   assign bus.m_data    = bus.m_valid ? mem_q[rd_q] : '0;
   assign bus.txn_count = cnt_q;

   // finish shows up in the same cycle the drained FIFO empties in FIN
   assign fin_now    = (state_q == FIN) && (occ_q == '0);
   assign bus.finish = fin_q || fin_now;

   assign accept  = bus.s_valid && bus.s_ready;
   assign done_ev = bus.ap_done &&
                    ((state_q == BUSY) ||
                     ((state_q == START) && bus.ap_ready));
   assign push    = done_ev && bus.ap_y_vld;
   assign pop     = bus.m_valid && bus.m_ready;

   // transaction sequencing and completion counting
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               x_d     = bus.s_data;
               state_d = START;
            end
         end
         START: begin
            if (done_ev) begin
               cnt_d   = cnt_inc;
               state_d = last ? FIN : IDLE;
            end else if (bus.ap_ready) begin
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (done_ev) begin
               cnt_d   = cnt_inc;
               state_d = last ? FIN : IDLE;
            end
         end
         FIN: state_d = FIN;
         default: state_d = IDLE;
      endcase
   end

   // control state registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         x_q     <= '0;
         cnt_q   <= '0;
         fin_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         cnt_q   <= cnt_d;
         fin_q   <= fin_q || fin_now;
      end
   end

   // FIFO pointers and occupancy; push and pop may coincide
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         occ_q <= '0;
      end else begin
         if (push) wr_q <= wr_q + 1'b1;
         if (pop)  rd_q <= rd_q + 1'b1;
         occ_q <= occ_q + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   // FIFO storage; contents are masked by m_valid so need no reset
   always_ff @(posedge clock) begin
      if (push) mem_q[wr_q] <= bus.ap_y;
   end

`ifdef FIR_DRV_STALL_CNT_EN
   logic [31:0] stall_q;
   logic [1:0]  stall_inc;

   assign stall_inc = 2'(bus.ap_start && !bus.ap_ready)
                    + 2'(bus.m_valid && !bus.m_ready);
   assign stall_cycles = stall_q;

   // saturating count of start and output back-pressure cycles
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         stall_q <= '0;
      else if (stall_q > (32'hFFFF_FFFF - 32'(stall_inc)))
         stall_q <= 32'hFFFF_FFFF;
      else
         stall_q <= stall_q + 32'(stall_inc);
   end
`endif

endmodule
